// File: rtl/disp_reg_mirror.sv
// Register-file mirror feeding the 8-digit register display, with debounced freeze and scan clock.
// Optional: define DISP_MIRROR_R0_ZERO_EN to hard-wire r0 to zero and drop writes to address 0.
module disp_reg_mirror #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic        freeze_btn,
  output logic [15:0] reg_0,
  output logic [15:0] reg_1,
  output logic [15:0] reg_2,
  output logic [15:0] reg_3,
  output logic [15:0] reg_4,
  output logic [15:0] reg_5,
  output logic [15:0] reg_6,
  output logic [15:0] reg_7,
  output logic        sl_clk,
  output logic        frozen
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

`ifdef DISP_MIRROR_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  logic [SW-1:0]  scan_cnt;
  logic           sync_1;
  logic           sync_2;
  logic           btn_level;
  logic [DW-1:0]  db_cnt;
  logic           press_accept;
  logic           unfreeze;
  logic [127:0]   display_bus;

  // Free-running scan divider; independent of freeze state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      sl_clk   <= 1'b0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      sl_clk   <= ~sl_clk;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Counter tracks how long the synchronized sample has disagreed with the accepted level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      btn_level <= 1'b0;
      db_cnt    <= '0;
    end else begin
      sync_1 <= freeze_btn;
      sync_2 <= sync_1;
      if (sync_2 == btn_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt    <= '0;
        btn_level <= sync_2;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign press_accept = sync_2 && !btn_level && (db_cnt == DB_LAST);
  assign unfreeze     = press_accept && frozen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frozen <= 1'b0;
    end else if (press_accept) begin
      frozen <= ~frozen;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_reg
      logic [15:0] shadow;
      logic [15:0] display;
      logic        hit;

      assign hit = wr_en && (wr_addr == 3'(gi)) && !(R0_ZERO && (gi == 0));

      // A write on the unfreeze cycle takes priority over the stale shadow copy.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          shadow  <= '0;
          display <= '0;
        end else begin
          if (hit) begin
            shadow <= wr_data;
          end
          if (hit && (!frozen || unfreeze)) begin
            display <= wr_data;
          end else if (unfreeze) begin
            display <= shadow;
          end
        end
      end

      assign display_bus[gi*16 +: 16] = display;
    end
  endgenerate

  assign reg_0 = display_bus[0*16 +: 16];
  assign reg_1 = display_bus[1*16 +: 16];
  assign reg_2 = display_bus[2*16 +: 16];
  assign reg_3 = display_bus[3*16 +: 16];
  assign reg_4 = display_bus[4*16 +: 16];
  assign reg_5 = display_bus[5*16 +: 16];
  assign reg_6 = display_bus[6*16 +: 16];
  assign reg_7 = display_bus[7*16 +: 16];

endmodule

// File: tb/tb_disp_reg_mirror.sv
// Directed self-checking bench for disp_reg_mirror with SCAN_DIV=4, DEBOUNCE_CYCLES=8.
module tb_disp_reg_mirror;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        freeze_btn;
  logic [15:0] r [8];
  logic        sl_clk;
  logic        frozen;

  int total = 0;
  int bad   = 0;

  disp_reg_mirror #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .freeze_btn(freeze_btn),
    .reg_0(r[0]), .reg_1(r[1]), .reg_2(r[2]), .reg_3(r[3]),
    .reg_4(r[4]), .reg_5(r[5]), .reg_6(r[6]), .reg_7(r[7]),
    .sl_clk(sl_clk), .frozen(frozen)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; freeze_btn = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      total++;
      if (r[i] !== 16'h0) begin
        bad++;
        $display("FAIL reset_reg%0d: got %h want 0000", i, r[i]);
      end
    end
    total++;
    if (sl_clk !== 1'b0 || frozen !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctl: sl_clk=%b frozen=%b want 0 0", sl_clk, frozen);
    end
    rst = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      total++;
      if (sl_clk !== 1'((k / 4) % 2)) begin
        bad++;
        $display("FAIL scan_clk cycle %0d: got %b want %b", k, sl_clk, 1'((k / 4) % 2));
      end
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (r[i] !== 16'h0) begin
        bad++;
        $display("FAIL idle_reg%0d: got %h want 0000", i, r[i]);
      end
    end
    total++;
    if (frozen !== 1'b0) begin
      bad++;
      $display("FAIL idle_frozen: got %b want 0", frozen);
    end
    $display("reset and scan clock run done");
  endtask

  task automatic test_write;
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF;
    tick();
    wr_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (r[i] !== ((i == 3) ? 16'hBEEF : 16'h0)) begin
        bad++;
        $display("FAIL write_reg%0d: got %h want %h", i, r[i], (i == 3) ? 16'hBEEF : 16'h0);
      end
    end
    $display("write r3=BEEF done");
  endtask

  task automatic test_freeze;
    freeze_btn = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      total++;
      if (frozen !== (k >= 10)) begin
        bad++;
        $display("FAIL freeze_latency cycle %0d: got %b want %b", k, frozen, k >= 10);
      end
    end
    freeze_btn = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h1234;
    tick();
    wr_en = 1'b0;
    total++;
    if (r[5] !== 16'h0) begin
      bad++;
      $display("FAIL frozen_hold: reg_5 got %h want 0000", r[5]);
    end
    for (int k = 0; k < 12; k++) tick();
    total++;
    if (frozen !== 1'b1 || r[5] !== 16'h0) begin
      bad++;
      $display("FAIL release_no_toggle: frozen=%b reg_5=%h want 1 0000", frozen, r[5]);
    end
    freeze_btn = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      total++;
      if (frozen !== (k < 10) || r[5] !== ((k >= 10) ? 16'h1234 : 16'h0)) begin
        bad++;
        $display("FAIL unfreeze cycle %0d: frozen=%b reg_5=%h want %b %h",
                 k, frozen, r[5], k < 10, (k >= 10) ? 16'h1234 : 16'h0);
      end
    end
    freeze_btn = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    $display("freeze/unfreeze with r5=1234 done");
  endtask

  task automatic test_unfreeze_bypass;
    freeze_btn = 1'b1;
    for (int k = 0; k < 12; k++) tick();
    freeze_btn = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    total++;
    if (frozen !== 1'b1) begin
      bad++;
      $display("FAIL bypass_freeze: frozen got %b want 1", frozen);
    end
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h0001;
    tick();
    wr_en = 1'b0;
    freeze_btn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      if (k == 10) begin
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h0002;
      end
      tick();
      wr_en = 1'b0;
      if (k == 9) begin
        total++;
        if (r[2] !== 16'h0 || frozen !== 1'b1) begin
          bad++;
          $display("FAIL bypass_pre: reg_2=%h frozen=%b want 0000 1", r[2], frozen);
        end
      end
    end
    total++;
    if (r[2] !== 16'h0002 || frozen !== 1'b0) begin
      bad++;
      $display("FAIL bypass_post: reg_2=%h frozen=%b want 0002 0", r[2], frozen);
    end
    total++;
    if (r[5] !== 16'h1234 || r[3] !== 16'hBEEF) begin
      bad++;
      $display("FAIL bypass_others: reg_5=%h reg_3=%h want 1234 BEEF", r[5], r[3]);
    end
    freeze_btn = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    $display("unfreeze-cycle write bypass r2=0002 done");
  endtask

  task automatic test_bounce;
    for (int c = 0; c < 42; c++) begin
      freeze_btn = (c < 30) && ((c % 5) < 3);
      tick();
      total++;
      if (frozen !== 1'b0) begin
        bad++;
        $display("FAIL bounce cycle %0d: frozen got %b want 0", c, frozen);
      end
    end
    freeze_btn = 1'b0;
    $display("bounce rejection done");
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp0;
`ifdef DISP_MIRROR_R0_ZERO_EN
    exp0 = 16'h0000;
`else
    exp0 = 16'hFFFF;
`endif
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'h1111;
    tick();
    total++;
    if (r[7] !== 16'h1111) begin
      bad++;
      $display("FAIL b2b_first: reg_7 got %h want 1111", r[7]);
    end
    wr_data = 16'h2222;
    tick();
    wr_addr = 3'd0; wr_data = 16'hFFFF;
    tick();
    wr_en = 1'b0;
    total++;
    if (r[7] !== 16'h2222) begin
      bad++;
      $display("FAIL b2b_last: reg_7 got %h want 2222", r[7]);
    end
    total++;
    if (r[0] !== exp0) begin
      bad++;
      $display("FAIL r0_write: reg_0 got %h want %h", r[0], exp0);
    end
    $display("back-to-back r7 and r0 write done");
  endtask

  task automatic test_mid_reset;
    freeze_btn = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (r[i] !== 16'h0) begin
        bad++;
        $display("FAIL midrst_reg%0d: got %h want 0000", i, r[i]);
      end
    end
    total++;
    if (sl_clk !== 1'b0 || frozen !== 1'b0) begin
      bad++;
      $display("FAIL midrst_ctl: sl_clk=%b frozen=%b want 0 0", sl_clk, frozen);
    end
    tick();
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k >= 9) begin
        total++;
        if (frozen !== (k == 10)) begin
          bad++;
          $display("FAIL post_reset_debounce cycle %0d: frozen got %b want %b", k, frozen, k == 10);
        end
      end
    end
    freeze_btn = 1'b0;
    $display("mid-operation reset done");
  endtask

  initial begin
    test_reset();
    test_write();
    test_freeze();
    test_unfreeze_bypass();
    test_bounce();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
